// File: rtl/hwpe_stream_tcdm_store_arbiter_pkg.sv
// Shared types and constants for the TCDM store-path arbiter.
// Holds the arbiter state encoding and the round-robin pointer helper.
package hwpe_stream_package;

    typedef enum logic {ARB_IDLE, ARB_BURST} tcdm_store_arb_state_t;

    localparam int unsigned TCDM_STORE_AW = 32;
    localparam int unsigned TCDM_STORE_DW = 32;

    // Successor of idx in a ring of n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_store_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i.
// Purely combinational; the caller owns the pointer register.
module hwpe_stream_rr_pick #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] sel_o,
    output logic          valid_o
);

    logic [2*N-1:0] w_req2;
    logic [N-1:0]   w_rot;

    // Rotating the doubled vector puts requester ptr_i at bit 0.
    assign w_req2 = {req_i, req_i};
    assign w_rot  = N'(w_req2 >> ptr_i);

    always_comb begin
        sel_o   = '0;
        valid_o = 1'b0;
        // Walk downwards so the smallest offset from ptr_i is written last.
        for (int unsigned j = N; j > 0; j--) begin
            if (w_rot[IW'(j - 1)]) begin
                sel_o   = IW'((32'(ptr_i) + j - 1) % N);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hwpe_stream_tcdm_store_arbiter.sv
// Round-robin arbiter sharing one TCDM store path among NB_IN requesters,
// with bounded burst ownership and a flush handshake that quiesces the path.
module hwpe_stream_tcdm_store_arbiter
    import hwpe_stream_package::*;
#(
    parameter  int unsigned NB_IN     = 4,
    parameter  int unsigned MAX_BURST = 4,
    parameter  int unsigned CNT_WIDTH = 32,
    localparam int unsigned IW        = (NB_IN > 1) ? $clog2(NB_IN) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  logic                              flush_i,
    output logic                              flush_done_o,
    input  logic [NB_IN-1:0]                  in_req_i,
    output logic [NB_IN-1:0]                  in_gnt_o,
    input  logic [NB_IN*TCDM_STORE_AW-1:0]    in_add_i,
    input  logic [NB_IN*TCDM_STORE_DW-1:0]    in_data_i,
    output logic                              out_req_o,
    input  logic                              out_gnt_i,
    output logic [TCDM_STORE_AW-1:0]          out_add_o,
    output logic [TCDM_STORE_DW-1:0]          out_data_o,
    output logic [IW-1:0]                     owner_o,
    output logic [CNT_WIDTH-1:0]              store_cnt_o
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    tcdm_store_arb_state_t r_state, w_state_nxt;
    logic [IW-1:0]         r_rr_ptr, w_rr_nxt;
    logic [IW-1:0]         r_owner, w_owner_nxt;
    logic [BW-1:0]         r_beat, w_beat_nxt;
    logic                  r_flush_pend;
    logic [CNT_WIDTH-1:0]  r_store_cnt;

    logic [IW-1:0]         w_pick_sel, w_sel;
    logic                  w_pick_valid;
    logic                  w_out_req, w_hs, w_flush_done;
    logic [NB_IN-1:0]      w_gnt;

    logic [TCDM_STORE_AW-1:0] w_add_arr  [NB_IN];
    logic [TCDM_STORE_DW-1:0] w_data_arr [NB_IN];

    hwpe_stream_rr_pick #(
        .N (NB_IN)
    ) i_rr_pick (
        .req_i   (in_req_i),
        .ptr_i   (r_rr_ptr),
        .sel_o   (w_pick_sel),
        .valid_o (w_pick_valid)
    );

    for (genvar g = 0; g < NB_IN; g++) begin : g_unpack
        assign w_add_arr[g]  = in_add_i[g*TCDM_STORE_AW +: TCDM_STORE_AW];
        assign w_data_arr[g] = in_data_i[g*TCDM_STORE_DW +: TCDM_STORE_DW];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_owner_nxt = r_owner;
        w_beat_nxt  = r_beat;
        w_sel       = r_owner;
        w_out_req   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (!r_flush_pend) begin
                    w_sel     = w_pick_sel;
                    w_out_req = w_pick_valid & ~rst_i;
                    if (w_pick_valid) begin
                        w_owner_nxt = w_pick_sel;
                        if (out_gnt_i && MAX_BURST == 1) begin
                            w_rr_nxt = IW'(rr_next(32'(w_pick_sel), NB_IN));
                        end else begin
                            // Lock the selection even on backpressure so add/data stay stable.
                            w_state_nxt = ARB_BURST;
                            w_beat_nxt  = out_gnt_i ? BW'(1) : '0;
                        end
                    end
                end
            end
            ARB_BURST: begin
                w_out_req = in_req_i[r_owner] & ~rst_i;
                if (!in_req_i[r_owner] ||
                    (out_gnt_i && (r_beat == BW'(MAX_BURST - 1) || r_flush_pend))) begin
                    w_state_nxt = ARB_IDLE;
                    w_rr_nxt    = IW'(rr_next(32'(r_owner), NB_IN));
                    w_beat_nxt  = '0;
                end else if (out_gnt_i) begin
                    w_beat_nxt = r_beat + BW'(1);
                end
            end
            default: ;
        endcase
    end

    assign w_hs         = w_out_req & out_gnt_i;
    assign w_flush_done = r_flush_pend & (r_state == ARB_IDLE);

    always_comb begin
        w_gnt = '0;
        if (w_hs) w_gnt[w_sel] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ARB_IDLE;
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_store_cnt  <= '0;
        end else if (clear_i) begin
            r_state      <= ARB_IDLE;
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_store_cnt  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_owner  <= w_owner_nxt;
            r_beat   <= w_beat_nxt;
            if (w_hs) r_store_cnt <= r_store_cnt + CNT_WIDTH'(1);
            // A flush arriving while one is already pending is absorbed by the done pulse.
            if (w_flush_done)  r_flush_pend <= 1'b0;
            else if (flush_i)  r_flush_pend <= 1'b1;
        end
    end

    assign out_req_o    = w_out_req;
    assign in_gnt_o     = w_gnt;
    assign out_add_o    = w_add_arr[w_sel];
    assign out_data_o   = w_data_arr[w_sel];
    assign owner_o      = r_owner;
    assign store_cnt_o  = r_store_cnt;
    assign flush_done_o = w_flush_done;

    // Requesters must hold their request until granted.
    for (genvar g = 0; g < NB_IN; g++) begin : g_hold
        a_req_hold: assert property (@(posedge clk_i)
            (in_req_i[g] && !w_gnt[g] && !rst_i && !clear_i) |=> (in_req_i[g] || rst_i));
    end

endmodule
